// File: rtl/pclk_pkg.sv
// Shared types and helpers for the power-clock step sequencer.
//   top_state_t  : sequencer top-level state (IDLE/RUN/DRAIN)
//   slot_state_t : per-phase position inside a period (RISE/HOLD/FALL/WAIT)
//   lvl_width    : bits needed for a step level 0..nstep
//   cnt_width    : bits needed for a counter 0..n-1 (at least 1)
//   slot_decode  : maps the relative slot distance (q-p) mod NPHASE to a slot state
package pclk_pkg;

    typedef enum logic [1:0] {
        TOP_IDLE  = 2'd0,
        TOP_RUN   = 2'd1,
        TOP_DRAIN = 2'd2
    } top_state_t;

    typedef enum logic [1:0] {
        SLOT_RISE = 2'd0,
        SLOT_HOLD = 2'd1,
        SLOT_FALL = 2'd2,
        SLOT_WAIT = 2'd3
    } slot_state_t;

    function automatic int lvl_width(input int nstep);
        return $clog2(nstep + 1);
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic slot_state_t slot_decode(input int rel);
        if (rel == 0)      return SLOT_RISE;
        else if (rel == 1) return SLOT_HOLD;
        else if (rel == 2) return SLOT_FALL;
        else               return SLOT_WAIT;
    endfunction

endpackage

// File: rtl/pclk_seg_therm.sv
// Drive-strength decode: saturates the requested segment count at SEG and
// converts it to a thermometer code (bit i set iff i < count).
//   strength : requested number of enabled segments (may exceed SEG)
//   therm    : thermometer-coded segment enables
module pclk_seg_therm #(
    parameter int SEG = 16,
    localparam int SW = $clog2(SEG + 1)
) (
    input  logic [SW-1:0]  strength,
    output logic [SEG-1:0] therm
);

    localparam logic [SW-1:0] SEG_MAX = SW'(SEG);

    logic [SW-1:0] sat;

    assign sat = (strength > SEG_MAX) ? SEG_MAX : strength;

    always_comb begin
        therm = '0;
        for (int i = 0; i < SEG; i++) begin
            therm[i] = (i < int'(sat));
        end
    end

endmodule

// File: rtl/pclk_step_seq.sv
// Multi-phase power-clock step sequencer. Each phase ramps vss->vdd->vss in
// NSTEP steps of DWELL cycles, phases staggered by one slot (NSTEP*DWELL
// cycles). Stepwise (adiabatic) or abrupt swing is latched at start of run.
//   clk, rst     : clock, async active-high reset
//   en           : run request (dropping it drains in-flight ramps)
//   mode         : 1 = stepwise ramp, 0 = abrupt swing
//   strength     : requested drive segment count, sampled at slot start
//   phase_lvl    : per-phase step level, phase p in slice p
//   seg_en       : thermometer segment enables shared by all phases
//   busy         : sequencer not idle
//   period_done  : pulse on the last cycle of every period
//
// state     | meaning
// ----------+-----------------------------------------------------------
// TOP_IDLE  | outputs quiet, counters parked at zero, waiting for en
// TOP_RUN   | all phases armed, ramps cycling continuously
// TOP_DRAIN | no new ramps start; in-flight ramps finish, then idle
module pclk_step_seq
    import pclk_pkg::*;
#(
    parameter int NPHASE = 4,
    parameter int NSTEP  = 4,
    parameter int DWELL  = 2,
    parameter int SEG    = 16,
    localparam int LW = lvl_width(NSTEP),
    localparam int SW = $clog2(SEG + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic [SW-1:0]        strength,
    output logic [NPHASE*LW-1:0] phase_lvl,
    output logic [SEG-1:0]       seg_en,
    output logic                 busy,
    output logic                 period_done
);

    localparam int QW  = cnt_width(NPHASE);
    localparam int SSW = cnt_width(NSTEP);
    localparam int DW  = cnt_width(DWELL);

    localparam logic [QW-1:0]  Q_LAST  = QW'(NPHASE - 1);
    localparam logic [SSW-1:0] S_LAST  = SSW'(NSTEP - 1);
    localparam logic [DW-1:0]  D_LOAD  = DW'(DWELL - 1);
    localparam logic [LW-1:0]  LVL_MAX = LW'(NSTEP);

    top_state_t      state, state_nx;
    logic [QW-1:0]   q, q_nx;
    logic [SSW-1:0]  s;
    logic [DW-1:0]   dcnt;
    logic            mode_q;
    logic [NPHASE-1:0] armed, armed_nx;
    logic [SEG-1:0]  seg_q, therm;
    logic            d_tc, s_tc, q_tc, slot_first, slot_end, draining;
    logic [LW-1:0]   lvl_rise, lvl_fall;

    function automatic int rel_of(input logic [QW-1:0] qq, input int p);
        return (int'(qq) + NPHASE - p) % NPHASE;
    endfunction

    // Dwell is a down-counter: dcnt == D_LOAD is dwell count 0, dcnt == 0 is
    // the last cycle of a step.
    assign d_tc       = (dcnt == '0);
    assign s_tc       = (s == S_LAST);
    assign q_tc       = (q == Q_LAST);
    assign slot_first = (s == '0) && (dcnt == D_LOAD);
    assign slot_end   = d_tc && s_tc;
    assign q_nx       = q_tc ? '0 : q + QW'(1);

    pclk_seg_therm #(.SEG(SEG)) u_therm (
        .strength (strength),
        .therm    (therm)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= TOP_IDLE;
            armed <= '0;
        end else begin
            state <= state_nx;
            armed <= armed_nx;
        end
    end

    // While draining, a phase keeps its arm only if the next slot continues
    // a ramp already under way (HOLD or FALL); entering RISE or WAIT disarms.
    always_comb begin
        state_nx = state;
        armed_nx = armed;
        draining = 1'b0;
        case (state)
            TOP_IDLE: begin
                if (en) begin
                    state_nx = TOP_RUN;
                    armed_nx = '1;
                end
            end
            TOP_RUN: begin
                if (!en) begin
                    state_nx = TOP_DRAIN;
                    draining = 1'b1;
                end
            end
            TOP_DRAIN: begin
                draining = 1'b1;
                if (armed == '0) state_nx = TOP_IDLE;
            end
            default: state_nx = TOP_IDLE;
        endcase
        if (draining && slot_end) begin
            for (int p = 0; p < NPHASE; p++) begin
                if (slot_decode(rel_of(q_nx, p)) == SLOT_RISE ||
                    slot_decode(rel_of(q_nx, p)) == SLOT_WAIT) begin
                    armed_nx[p] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q      <= '0;
            s      <= '0;
            dcnt   <= D_LOAD;
            mode_q <= 1'b0;
            seg_q  <= '0;
        end else if (state == TOP_IDLE) begin
            q     <= '0;
            s     <= '0;
            dcnt  <= D_LOAD;
            seg_q <= '0;
            if (en) mode_q <= mode;
        end else begin
            if (slot_first) seg_q <= therm;
            if (d_tc) begin
                dcnt <= D_LOAD;
                if (s_tc) begin
                    s <= '0;
                    q <= q_nx;
                end else begin
                    s <= s + SSW'(1);
                end
            end else begin
                dcnt <= dcnt - DW'(1);
            end
        end
    end

    assign busy        = (state != TOP_IDLE);
    assign period_done = busy && slot_end && q_tc;
    assign seg_en      = busy ? seg_q : '0;
    assign lvl_rise    = LW'(s) + LW'(1);
    assign lvl_fall    = LVL_MAX - LW'(1) - LW'(s);

    always_comb begin
        phase_lvl = '0;
        for (int p = 0; p < NPHASE; p++) begin
            if (busy && armed[p]) begin
                case (slot_decode(rel_of(q, p)))
                    SLOT_RISE: phase_lvl[p*LW +: LW] = mode_q ? lvl_rise : LVL_MAX;
                    SLOT_HOLD: phase_lvl[p*LW +: LW] = LVL_MAX;
                    SLOT_FALL: phase_lvl[p*LW +: LW] = mode_q ? lvl_fall : '0;
                    default:   phase_lvl[p*LW +: LW] = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pclk_step_seq.sv
// Bench for pclk_step_seq at default parameters.
module tb_pclk_step_seq;

    localparam int NPHASE = 4;
    localparam int LW     = 3;
    localparam int SEG    = 16;
    localparam int SW     = 5;

    logic                 clk = 1'b0;
    logic                 rst, en, mode;
    logic [SW-1:0]        strength;
    logic [NPHASE*LW-1:0] phase_lvl;
    logic [SEG-1:0]       seg_en;
    logic                 busy, period_done;

    pclk_step_seq dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .strength    (strength),
        .phase_lvl   (phase_lvl),
        .seg_en      (seg_en),
        .busy        (busy),
        .period_done (period_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NPHASE*LW-1:0] lvl;
        logic                 busy;
        logic                 pd;
        logic [SEG-1:0]       seg;
    } exp_t;

    typedef struct {
        logic [SW-1:0]  str;
        logic [SEG-1:0] seg;
    } tv_t;

    exp_t sbq[$];
    tv_t  tab[8];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Phase-0 stepwise waveform over one 32-cycle period.
    int wave1[32] = '{1,1,2,2,3,3,4,4, 4,4,4,4,4,4,4,4,
                      3,3,2,2,1,1,0,0, 0,0,0,0,0,0,0,0};

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // c: cycle number inside the run (1 = first RUN cycle); drain applies the
    // en-drop-at-cycle-10 disarm pattern.
    function automatic exp_t mk_exp(input int m, input int c, input bit drain,
                                    input logic b, input logic pd, input logic [SEG-1:0] sg);
        exp_t e;
        e.lvl  = '0;
        e.busy = b;
        e.pd   = pd;
        e.seg  = sg;
        for (int p = 0; p < NPHASE; p++) begin
            int idx;
            int v;
            idx = (((c - 1 - 8*p) % 32) + 32) % 32;
            v   = (m != 0) ? wave1[idx] : ((idx < 16) ? 4 : 0);
            if (drain && (c > 32 || (p >= 2 && c > 16))) v = 0;
            e.lvl[p*LW +: LW] = 3'(v);
        end
        return e;
    endfunction

    task automatic step_check(input string tag, input exp_t e);
        exp_t g;
        sbq.push_back(e);
        tick();
        g = sbq.pop_front();
        check({tag, "_lvl"},  32'(phase_lvl),   32'(g.lvl));
        check({tag, "_busy"}, 32'(busy),        32'(g.busy));
        check({tag, "_pd"},   32'(period_done), 32'(g.pd));
        check({tag, "_seg"},  32'(seg_en),      32'(g.seg));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        tab[0] = '{5'd0,  16'h0000};
        tab[1] = '{5'd1,  16'h0001};
        tab[2] = '{5'd5,  16'h001F};
        tab[3] = '{5'd15, 16'h7FFF};
        tab[4] = '{5'd16, 16'hFFFF};
        tab[5] = '{5'd17, 16'hFFFF};
        tab[6] = '{5'd20, 16'hFFFF};
        tab[7] = '{5'd31, 16'hFFFF};

        rst = 1'b1; en = 1'b0; mode = 1'b0; strength = '0;
        tick();
        tick();
        check("rst_lvl",  32'(phase_lvl),   32'h0);
        check("rst_seg",  32'(seg_en),      32'h0);
        check("rst_busy", 32'(busy),        32'h0);
        check("rst_pd",   32'(period_done), 32'h0);

        // Stepwise run; strength 20 saturates, drops to 5 mid-slot; mode toggles ignored.
        rst = 1'b0; en = 1'b1; mode = 1'b1; strength = 5'd20; cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            logic [SEG-1:0] sg;
            if (c == 5)  strength = 5'd5;
            if (c == 13) mode = 1'b0;
            if (c == 25) mode = 1'b1;
            if (c == 30) mode = 1'b0;
            sg = (c == 1) ? 16'h0000 : (c <= 9) ? 16'hFFFF : 16'h001F;
            step_check("run1", mk_exp(1, c, 1'b0, 1'b1, c % 32 == 0, sg));
        end

        // Drop en during cycle 10 and drain.
        do_reset();
        en = 1'b1; mode = 1'b1; strength = 5'd3; cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            logic [SEG-1:0] sg;
            if (c == 11) en = 1'b0;
            sg = (c == 1 || c > 33) ? 16'h0000 : 16'h0007;
            step_check("drain", mk_exp(1, c, 1'b1, c <= 33, c == 32, sg));
        end

        // Restart from IDLE in abrupt mode, then async reset between edges.
        mode = 1'b0; en = 1'b1; cyc = 0;
        for (int c = 1; c <= 18; c++) begin
            step_check("run0", mk_exp(0, c, 1'b0, 1'b1, 1'b0, (c == 1) ? 16'h0000 : 16'h0007));
        end
        #3;
        rst = 1'b1;
        #1;
        check("arst_lvl",  32'(phase_lvl),   32'h0);
        check("arst_seg",  32'(seg_en),      32'h0);
        check("arst_busy", 32'(busy),        32'h0);
        check("arst_pd",   32'(period_done), 32'h0);
        tick();
        do_reset();

        // Strength table: set mid-slot, visible one cycle after the next slot start.
        en = 1'b1; mode = 1'b1; strength = '0; cyc = 0;
        for (int k = 0; k <= 8; k++) begin
            for (int i = 1; i <= 8; i++) begin
                if (i == 5 && k < 8) strength = tab[k].str;
                tick();
                if (i == 1 && k >= 2) check("tab_hold", 32'(seg_en), 32'(tab[k-2].seg));
                if (i == 2 && k >= 1) check("tab_seg",  32'(seg_en), 32'(tab[k-1].seg));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
